// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA scan-out path.
// 640x480@60 timing, NES window placement and the border colour index.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int X_OFFSET = 64;
    localparam int NES_W    = 512;

    typedef logic [5:0] pal_idx_t;

    localparam pal_idx_t BORDER_IDX = 6'h0F;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Sync flags are carried active-high so a cleared pipeline never emits a pulse.
    typedef struct packed {
        logic active;
        logic win;
        logic hsync;
        logic vsync;
    } ctl_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Read-only memory bus between the scan-out block and its VRAM port B / CROM.
// Both memories return data one clock after the address is presented.
interface vga_scanout_if;
    import vga_pkg::*;

    logic [15:0] vram_addr;
    logic [7:0]  vram_q;
    pal_idx_t    crom_addr;
    rgb444_t     crom_data;

    modport master (
        output vram_addr,
        output crom_addr,
        input  vram_q,
        input  crom_data
    );

    modport slave (
        input  vram_addr,
        input  crom_addr,
        output vram_q,
        output crom_data
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running pixel/line counters plus the undelayed stage-0 decode.
// frame_start is timed from the next counter state so it coincides with (0, V_ACTIVE).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_PULSE = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic       clk,
    input  logic       n_rst,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       active,
    output logic       win,
    output logic       hs0,
    output logic       vs0,
    output logic       frame_start
);

    localparam int V_TOT = V_ACT + V_FRONT + V_PULSE + V_BACK;

    logic [9:0] hcnt_nxt;
    logic [9:0] vcnt_nxt;

    always_comb begin
        hcnt_nxt = hcnt + 10'd1;
        vcnt_nxt = vcnt;
        if (hcnt == 10'(H_TOTAL - 1)) begin
            hcnt_nxt = '0;
            vcnt_nxt = (vcnt == 10'(V_TOT - 1)) ? '0 : vcnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            frame_start <= (hcnt_nxt == '0) && (vcnt_nxt == 10'(V_ACT));
        end
    end

    assign active = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACT));
    assign win    = active && (hcnt >= 10'(X_OFFSET)) && (hcnt < 10'(X_OFFSET + NES_W));
    assign hs0    = !((hcnt >= 10'(H_ACTIVE + H_FP)) &&
                      (hcnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs0    = !((vcnt >= 10'(V_ACT + V_FRONT)) &&
                      (vcnt <  10'(V_ACT + V_FRONT + V_PULSE)));

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: fetches NES palette indices, looks up RGB444 and drives the pins.
// Counter-to-pin latency is a fixed 4 clocks for colour, sync and blank alike.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_PULSE = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic          clk,
    input  logic          n_rst,
    vga_scanout_if.master mem,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank_n,
    output logic          frame_start
);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       active;
    logic       win;
    logic       hs0;
    logic       vs0;

    vga_timing_gen #(
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_PULSE (V_PULSE),
        .V_BACK  (V_BACK)
    ) u_timing (
        .clk         (clk),
        .n_rst       (n_rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .active      (active),
        .win         (win),
        .hs0         (hs0),
        .vs0         (vs0),
        .frame_start (frame_start)
    );

    // 2x scaling: every NES pixel covers two columns and two lines.
    logic [9:0] x_off;
    logic [7:0] x_nes;
    logic [7:0] y_nes;

    assign x_off = hcnt - 10'(X_OFFSET);
    assign x_nes = x_off[8:1];
    assign y_nes = vcnt[8:1];

    logic unused_bits;
    assign unused_bits = ^{x_off[9], x_off[0], vcnt[9], vcnt[0], mem.vram_q[7:6]};

    ctl_t    ctl_d1;
    ctl_t    ctl_d2;
    ctl_t    ctl_d3;
    rgb444_t pix;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem.vram_addr <= '0;
            ctl_d1        <= '0;
            ctl_d2        <= '0;
            ctl_d3        <= '0;
            pix           <= '0;
            vga_hs        <= 1'b1;
            vga_vs        <= 1'b1;
            vga_blank_n   <= 1'b0;
        end else begin
            if (win) begin
                mem.vram_addr <= {y_nes, x_nes};
            end
            ctl_d1      <= {active, win, !hs0, !vs0};
            ctl_d2      <= ctl_d1;
            ctl_d3      <= ctl_d2;
            pix         <= ctl_d3.active ? mem.crom_data : '0;
            vga_hs      <= !ctl_d3.hsync;
            vga_vs      <= !ctl_d3.vsync;
            vga_blank_n <= ctl_d3.active;
        end
    end

    // vram_q is aligned with ctl_d2; outside the window the stale data is ignored.
    assign mem.crom_addr = ctl_d2.win ? mem.vram_q[5:0] : BORDER_IDX;

    assign vga_r = pix.r;
    assign vga_g = pix.g;
    assign vga_b = pix.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: random VRAM/CROM contents, a cycle-position reference model,
// sync-edge timing checks and an asynchronous mid-frame reset. Vertical timing is shortened.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = VA + VF + VS + VB;
    localparam int HT = 800;
    localparam int FRAME = VT * HT;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       frame_start;

    vga_scanout_if mem ();

    vga_scanout #(
        .V_ACT   (VA),
        .V_FRONT (VF),
        .V_PULSE (VS),
        .V_BACK  (VB)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .mem         (mem),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .frame_start (frame_start)
    );

    // clock / reset
    always #20 clk = ~clk;

    // memory models: registered reads, one clock of latency
    logic [7:0]  vram [65536];
    logic [11:0] crom [64];

    always @(posedge clk) begin
        mem.vram_q    <= vram[mem.vram_addr];
        mem.crom_data <= crom[mem.crom_addr];
    end

    // scoreboard state
    int          total = 0;
    int          bad = 0;
    int          k;
    logic [15:0] exp_vaddr;
    logic        prev_hs;
    logic        prev_vs;
    int          hs_falls;
    int          hs_last_fall;
    int          fs_count;
    bit          directed_on;

    int          dir_n    [5];
    logic [15:0] dir_addr [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // reference model: counter position n cycles after reset release
    function automatic int hpos(input int n);
        return n % HT;
    endfunction

    function automatic int vpos(input int n);
        return (n / HT) % VT;
    endfunction

    function automatic bit in_active(input int n);
        return hpos(n) < 640 && vpos(n) < VA;
    endfunction

    function automatic bit in_win(input int n);
        return in_active(n) && hpos(n) >= 64 && hpos(n) < 576;
    endfunction

    function automatic logic [15:0] nes_addr(input int n);
        int x;
        int y;
        x = (hpos(n) - 64) / 2;
        y = vpos(n) / 2;
        return 16'(y * 256 + x);
    endfunction

    // {hs, vs, blank_n, rgb}
    function automatic logic [14:0] exp_pins(input int n);
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic [7:0]  q;
        if (n < 0) return {1'b1, 1'b1, 1'b0, 12'h000};
        rgb = 12'h000;
        if (in_active(n)) begin
            if (in_win(n)) begin
                q = vram[nes_addr(n)];
                rgb = crom[q[5:0]];
            end else begin
                rgb = crom[15];
            end
        end
        hs = !(hpos(n) >= 656 && hpos(n) < 752);
        vs = !(vpos(n) >= VA + VF && vpos(n) < VA + VF + VS);
        return {hs, vs, in_active(n), rgb};
    endfunction

    function automatic logic [5:0] exp_crom_addr(input int n);
        logic [7:0] q;
        if (n < 0 || !in_win(n)) return 6'h0F;
        q = vram[nes_addr(n)];
        return q[5:0];
    endfunction

    task automatic start_segment();
        k            = 0;
        exp_vaddr    = 16'h0000;
        prev_hs      = 1'b1;
        prev_vs      = 1'b1;
        hs_falls     = 0;
        hs_last_fall = 0;
        fs_count     = 0;
    endtask

    task automatic end_segment();
        check("hs_fall_count", hs_falls, (k >= 660) ? (k - 660) / HT + 1 : 0);
        check("frame_start_count", fs_count, (k >= VA * HT) ? (k - VA * HT) / FRAME + 1 : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pins"}, {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b},
              {1'b1, 1'b1, 1'b0, 12'h000});
        check({tag, "_vram_addr"}, mem.vram_addr, 16'h0000);
        check({tag, "_crom_addr"}, mem.crom_addr, 6'h0F);
        check({tag, "_frame_start"}, frame_start, 1'b0);
    endtask

    // one clock per iteration, sampled 1 ns after the rising edge
    task automatic run(input int n_cycles);
        for (int i = 0; i < n_cycles; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (in_win(k - 1)) exp_vaddr = nes_addr(k - 1);
            check("pins", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}, exp_pins(k - 4));
            check("crom_addr", mem.crom_addr, exp_crom_addr(k - 2));
            check("vram_addr", mem.vram_addr, exp_vaddr);
            check("frame_start", frame_start, hpos(k) == 0 && vpos(k) == VA);
            if (frame_start) fs_count++;

            if (prev_hs && !vga_hs) begin
                hs_falls++;
                if (hs_falls == 1) check("hs_first_fall", k, 660);
                else check("hs_period", k - hs_last_fall, HT);
                hs_last_fall = k;
            end
            if (!prev_hs && vga_hs) check("hs_width", k - hs_last_fall, 96);
            if (prev_vs && !vga_vs) check("vs_fall_pos", k % FRAME, (VA + VF) * HT + 4);
            if (!prev_vs && vga_vs) check("vs_rise_pos", k % FRAME, (VA + VF + VS) * HT + 4);
            prev_hs = vga_hs;
            prev_vs = vga_vs;

            if (directed_on) begin
                for (int d = 0; d < 5; d++) begin
                    if (k - 1 == dir_n[d]) check("addr_map", mem.vram_addr, dir_addr[d]);
                end
                if (k == 64 + 4) begin
                    check("pix_64_0_rgb", {vga_r, vga_g, vga_b}, 12'h5BF);
                    check("pix_64_0_blank", vga_blank_n, 1'b1);
                end
                if (k == 7 * HT + 10 + 2) check("border_crom_addr", mem.crom_addr, 6'h0F);
                if (k == 7 * HT + 10 + 4) begin
                    check("border_rgb", {vga_r, vga_g, vga_b}, 12'h000);
                    check("border_blank", vga_blank_n, 1'b1);
                end
                if (k == 7 * HT + 700 + 4) begin
                    check("hblank_rgb", {vga_r, vga_g, vga_b}, 12'h000);
                    check("hblank_blank", vga_blank_n, 1'b0);
                end
            end
        end
    endtask

    initial begin
        int target;
        int wait_cycles;
        int hold;

        for (int a = 0; a < 65536; a++) vram[a] = 8'($urandom);
        for (int c = 0; c < 64; c++) crom[c] = 12'($urandom);
        vram[0]     = 8'h21;
        crom[6'h21] = 12'h5BF;
        crom[6'h0F] = 12'h000;

        dir_n    = '{64, 65, 66, 2 * HT + 64, 11 * HT + 575};
        dir_addr = '{16'h0000, 16'h0000, 16'h0001, 16'h0100, 16'h05FF};

        k = 0;
        directed_on = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_hold");

        n_rst = 1'b1;
        start_segment();
        run(2 * FRAME + 600);
        end_segment();
        directed_on = 1'b0;

        // asynchronous reset at a random frame position
        target      = $urandom_range(VT - 1, 0) * HT + $urandom_range(HT - 1, 0);
        wait_cycles = (target - (k % FRAME) + FRAME) % FRAME;
        run(wait_cycles + 4);
        #4;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid");

        hold = $urandom_range(8, 2);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid_hold");
        n_rst = 1'b1;
        start_segment();
        run(2000);
        end_segment();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
